// File: rtl/hi_fanout_bank_if.sv
// Bus bundle for hi_fanout_bank: driver/mode/enable/BIST controls in, load bus and monitors out.
interface hi_fanout_bank_if #(
    parameter int NUM_DRVR   = 2,
    parameter int NUM_LOADS  = 150,
    parameter int GROUP_SIZE = 16
);
    localparam int NUM_GRP = (NUM_LOADS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int CNT_W   = $clog2(NUM_LOADS + 1);

    logic [NUM_DRVR-1:0]  data;
    logic [1:0]           mode;
    logic [NUM_GRP-1:0]   grp_en;
    logic                 bist_start;
    logic [NUM_LOADS-1:0] outputs;
    logic [CNT_W-1:0]     ones_cnt;
    logic                 bist_done;
    logic                 bist_pass;

    modport master (
        output data, mode, grp_en, bist_start,
        input  outputs, ones_cnt, bist_done, bist_pass
    );

    modport slave (
        input  data, mode, grp_en, bist_start,
        output outputs, ones_cnt, bist_done, bist_pass
    );
endinterface

// File: rtl/hi_fanout_bank.sv
// High-fanout stress bank: driver flops -> one reduction net -> NUM_LOADS load flops,
// with grouped load enables, a registered popcount and a fill/check self-test.
module hi_fanout_load (
    input  logic clk1,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk1) begin
        if (!rst_n)  q <= 1'b0;
        else if (en) q <= d;
    end
endmodule

module hi_fanout_bank #(
    parameter int NUM_DRVR   = 2,
    parameter int NUM_LOADS  = 150,
    parameter int GROUP_SIZE = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    hi_fanout_bank_if.slave  bus
);
    localparam int NUM_GRP = (NUM_LOADS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int CNT_W   = $clog2(NUM_LOADS + 1);

    typedef enum logic [2:0] {
        IDLE, FILL0, CHK0, FILL1, CHK1, DONE
    } bist_state_t;

    bist_state_t          state, state_nxt;
    logic [NUM_DRVR-1:0]  drv;
    logic                 fan_net;
    logic                 load_d;
    logic                 force_all, force_val, hold, chk_err;
    logic                 fail;
    logic [NUM_LOADS-1:0] q_bus;
    logic [CNT_W-1:0]     cnt_nxt, cnt_q;
    logic                 done_q, pass_q;

    always_ff @(posedge clk1) begin
        if (!rst_n) drv <= '0;
        else        drv <= bus.data;
    end

    // fan_net must stay one net so the fanout tool has a single driver to repair
    always_comb begin
        fan_net = 1'b0;
        case (bus.mode)
            2'd0: fan_net = ~&drv;
            2'd1: fan_net =  &drv;
            2'd2: fan_net =  ^drv;
            2'd3: fan_net =  |drv;
            default: fan_net = 1'b0;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        force_all = 1'b0;
        force_val = 1'b0;
        hold      = 1'b0;
        chk_err   = 1'b0;
        case (state)
            IDLE:  if (bus.bist_start) state_nxt = FILL0;
            FILL0: begin force_all = 1'b1; force_val = 1'b0; state_nxt = CHK0; end
            CHK0:  begin hold = 1'b1; chk_err = (q_bus != '0); state_nxt = FILL1; end
            FILL1: begin force_all = 1'b1; force_val = 1'b1; state_nxt = CHK1; end
            CHK1:  begin hold = 1'b1; chk_err = (q_bus != '1); state_nxt = DONE; end
            DONE:  begin hold = 1'b1; state_nxt = IDLE; end
            default: state_nxt = IDLE;
        endcase
    end

    assign load_d = force_all ? force_val : fan_net;

    // Last group may be partial; k/GROUP_SIZE maps each load onto its enable bit
    for (genvar k = 0; k < NUM_LOADS; k++) begin : gen_load
        logic en;
        assign en = force_all | (!hold & bus.grp_en[k / GROUP_SIZE]);
        hi_fanout_load u_load (
            .clk1  (clk1),
            .rst_n (rst_n),
            .en    (en),
            .d     (load_d),
            .q     (q_bus[k])
        );
    end

    always_comb begin
        cnt_nxt = '0;
        for (int k = 0; k < NUM_LOADS; k++) cnt_nxt = cnt_nxt + CNT_W'(q_bus[k]);
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            fail   <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            done_q <= (state == DONE);
            if (state == IDLE && bus.bist_start) begin
                fail   <= 1'b0;
                pass_q <= 1'b0;
            end else if (chk_err) begin
                fail   <= 1'b1;
            end
            if (state == DONE) pass_q <= !fail;
        end
    end

    assign bus.outputs   = q_bus;
    assign bus.ones_cnt  = cnt_q;
    assign bus.bist_done = done_q;
    assign bus.bist_pass = pass_q;
endmodule

// File: tb/tb_hi_fanout_bank.sv
// Directed bench for hi_fanout_bank at default parameters (2 drivers, 150 loads, 10 groups).
module tb_hi_fanout_bank;
    localparam int NL = 150;

    logic clk1 = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [NL-1:0] all1;
    logic [NL-1:0] exp_o;

    hi_fanout_bank_if bif ();

    hi_fanout_bank dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bif.data = 2'b11; bif.mode = 2'd0; bif.grp_en = '1; bif.bist_start = 1'b0;
        tick(); tick();
        n_chk++; if (bif.outputs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", bif.outputs); end
        n_chk++; if (bif.ones_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", bif.ones_cnt); end
        n_chk++; if (bif.bist_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bif.bist_done); end
        n_chk++; if (bif.bist_pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got=%b exp=0", bif.bist_pass); end
        rst_n = 1'b1;
    endtask

    task automatic test_modes();
        bif.data = 2'b10; bif.mode = 2'd0; bif.grp_en = '1;
        tick(); tick();
        n_chk++; if (bif.outputs !== all1) begin n_fail++; $display("FAIL nand_outputs got=%h exp=%h", bif.outputs, all1); end
        tick();
        n_chk++; if (bif.ones_cnt !== 8'd150) begin n_fail++; $display("FAIL nand_cnt got=%0d exp=150", bif.ones_cnt); end
        bif.mode = 2'd1; tick(); tick();
        n_chk++; if (bif.outputs !== '0) begin n_fail++; $display("FAIL and_outputs got=%h exp=0", bif.outputs); end
        n_chk++; if (bif.ones_cnt !== 8'd0) begin n_fail++; $display("FAIL and_cnt got=%0d exp=0", bif.ones_cnt); end
        bif.mode = 2'd2; tick(); tick();
        n_chk++; if (bif.outputs !== all1) begin n_fail++; $display("FAIL xor_outputs got=%h exp=%h", bif.outputs, all1); end
        bif.mode = 2'd1; tick(); tick();
        bif.mode = 2'd3; tick(); tick();
        n_chk++; if (bif.outputs !== all1) begin n_fail++; $display("FAIL or_outputs got=%h exp=%h", bif.outputs, all1); end
        // XOR of 11 is 0; then AND of 11 is 1 with a two-cycle data latency
        bif.data = 2'b11; bif.mode = 2'd2; tick(); tick();
        n_chk++; if (bif.outputs !== '0) begin n_fail++; $display("FAIL xor11_outputs got=%h exp=0", bif.outputs); end
        bif.data = 2'b01; bif.mode = 2'd1; tick(); tick();
        bif.data = 2'b11; tick();
        n_chk++; if (bif.outputs !== '0) begin n_fail++; $display("FAIL latency_1cyc got=%h exp=0", bif.outputs); end
        tick();
        n_chk++; if (bif.outputs !== all1) begin n_fail++; $display("FAIL latency_2cyc got=%h exp=%h", bif.outputs, all1); end
    endtask

    task automatic test_groups();
        bif.data = 2'b10; bif.mode = 2'd1; bif.grp_en = '1;
        tick(); tick();
        bif.mode = 2'd0; bif.grp_en = 10'h200;
        tick();
        exp_o = '0;
        for (int k = 144; k < 150; k++) exp_o[k] = 1'b1;
        n_chk++; if (bif.outputs !== exp_o) begin n_fail++; $display("FAIL grp_last_outputs got=%h exp=%h", bif.outputs, exp_o); end
        tick();
        n_chk++; if (bif.ones_cnt !== 8'd6) begin n_fail++; $display("FAIL grp_last_cnt got=%0d exp=6", bif.ones_cnt); end
        bif.grp_en = 10'h001;
        tick();
        for (int k = 0; k < 16; k++) exp_o[k] = 1'b1;
        n_chk++; if (bif.outputs !== exp_o) begin n_fail++; $display("FAIL grp_first_outputs got=%h exp=%h", bif.outputs, exp_o); end
        tick();
        n_chk++; if (bif.ones_cnt !== 8'd22) begin n_fail++; $display("FAIL grp_first_cnt got=%0d exp=22", bif.ones_cnt); end
    endtask

    task automatic test_bist_pass();
        bif.grp_en = '0;
        bif.bist_start = 1'b1; tick(); bif.bist_start = 1'b0;   // E0 -> FILL0
        tick();                                                 // E1 -> CHK0
        n_chk++; if (bif.outputs !== '0) begin n_fail++; $display("FAIL bist_fill0 got=%h exp=0", bif.outputs); end
        n_chk++; if (bif.bist_done !== 1'b0) begin n_fail++; $display("FAIL bist_early_done1 got=%b exp=0", bif.bist_done); end
        tick();                                                 // E2 -> FILL1
        bif.bist_start = 1'b1; tick(); bif.bist_start = 1'b0;   // E3 -> CHK1
        tick();                                                 // E4 -> DONE
        n_chk++; if (bif.bist_done !== 1'b0) begin n_fail++; $display("FAIL bist_early_done4 got=%b exp=0", bif.bist_done); end
        tick();                                                 // E5
        n_chk++; if (bif.bist_done !== 1'b1) begin n_fail++; $display("FAIL bist_done got=%b exp=1", bif.bist_done); end
        n_chk++; if (bif.bist_pass !== 1'b1) begin n_fail++; $display("FAIL bist_pass got=%b exp=1", bif.bist_pass); end
        n_chk++; if (bif.outputs !== all1) begin n_fail++; $display("FAIL bist_fill1 got=%h exp=%h", bif.outputs, all1); end
        tick();
        n_chk++; if (bif.bist_done !== 1'b0) begin n_fail++; $display("FAIL bist_done_pulse got=%b exp=0", bif.bist_done); end
        n_chk++; if (bif.bist_pass !== 1'b1) begin n_fail++; $display("FAIL bist_pass_hold got=%b exp=1", bif.bist_pass); end
        n_chk++; if (bif.outputs !== all1) begin n_fail++; $display("FAIL bist_outputs_kept got=%h exp=%h", bif.outputs, all1); end
    endtask

    task automatic test_bist_fail();
        force dut.gen_load[73].u_load.q = 1'b0;
        bif.bist_start = 1'b1; tick(); bif.bist_start = 1'b0;
        repeat (5) tick();
        n_chk++; if (bif.bist_done !== 1'b1) begin n_fail++; $display("FAIL stuck_done got=%b exp=1", bif.bist_done); end
        n_chk++; if (bif.bist_pass !== 1'b0) begin n_fail++; $display("FAIL stuck_pass got=%b exp=0", bif.bist_pass); end
        release dut.gen_load[73].u_load.q;
        tick();
        bif.bist_start = 1'b1; tick(); bif.bist_start = 1'b0;
        repeat (5) tick();
        n_chk++; if (bif.bist_done !== 1'b1) begin n_fail++; $display("FAIL clean_done got=%b exp=1", bif.bist_done); end
        n_chk++; if (bif.bist_pass !== 1'b1) begin n_fail++; $display("FAIL clean_pass got=%b exp=1", bif.bist_pass); end
    endtask

    task automatic test_reset_mid_bist();
        tick();
        bif.bist_start = 1'b1; tick(); bif.bist_start = 1'b0;   // FILL0
        n_chk++; if (bif.bist_pass !== 1'b0) begin n_fail++; $display("FAIL start_clears_pass got=%b exp=0", bif.bist_pass); end
        tick();                                                 // CHK0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_chk++; if (bif.outputs !== '0) begin n_fail++; $display("FAIL midrst_outputs got=%h exp=0", bif.outputs); end
        for (int i = 0; i < 6; i++) begin
            n_chk++; if (bif.bist_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done cyc=%0d got=%b exp=0", i, bif.bist_done); end
            tick();
        end
        bif.bist_start = 1'b1; tick(); bif.bist_start = 1'b0;
        repeat (5) tick();
        n_chk++; if (bif.bist_done !== 1'b1) begin n_fail++; $display("FAIL fresh_done got=%b exp=1", bif.bist_done); end
        n_chk++; if (bif.bist_pass !== 1'b1) begin n_fail++; $display("FAIL fresh_pass got=%b exp=1", bif.bist_pass); end
    endtask

    initial begin
        all1 = '1;
        exp_o = '0;
        test_reset();
        test_modes();
        test_groups();
        test_bist_pass();
        test_bist_fail();
        test_reset_mid_bist();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
